// File: rtl/uart_word_bridge.sv
// uart_word_bridge: byte<->word bridge sitting on the FIFO side of the UART.
// RX assembles show-ahead FIFO bytes LSB-first into words on a valid/ready
// port, with an inter-byte timeout that drops stale partial words.
// TX serialises words LSB-first into the transmit FIFO, honouring FIFO-full.
module uart_word_bridge #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_empty,
    input  logic [7:0]        i_rx_data,
    output logic              o_rd_uart,
    input  logic              i_tx_full,
    output logic              o_wr_uart,
    output logic [7:0]        o_w_data,
    output logic              o_word_valid,
    output logic [DATA_W-1:0] o_word,
    input  logic              i_word_ready,
    input  logic              i_word_valid,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_word_ready,
    output logic              o_rx_err
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CW     = (NBYTES > 1)  ? $clog2(NBYTES)  : 1;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    // Only meaningful when TIMEOUT != 0; the timeout path is disabled otherwise.
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT - 1);

    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND}    tx_state_t;

    rx_state_t         rx_state, rx_state_nx;
    tx_state_t         tx_state, tx_state_nx;
    logic [CW-1:0]     rx_cnt;
    logic [TW-1:0]     rx_tcnt;
    logic [CW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_sr;
    logic              rx_pop, rx_last, rx_timeout;
    logic              tx_load, tx_push, tx_last;

    // State registers for both independent FSMs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_state <= RX_COLLECT;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_state_nx;
            tx_state <= tx_state_nx;
        end
    end

    // RX next-state and pop/timeout decode; strobes are gated off during reset.
    always_comb begin
        rx_state_nx = rx_state;
        rx_pop      = 1'b0;
        rx_last     = 1'b0;
        rx_timeout  = 1'b0;
        case (rx_state)
            RX_COLLECT: begin
                rx_pop     = i_reset & ~i_rx_empty;
                rx_last    = rx_pop && (rx_cnt == LAST_BYTE);
                rx_timeout = (TIMEOUT != 0) && !rx_pop && (rx_cnt != '0) &&
                             (rx_tcnt == TO_LIMIT);
                if (rx_last) rx_state_nx = RX_HOLD;
            end
            RX_HOLD: begin
                if (i_word_ready) rx_state_nx = RX_COLLECT;
            end
            default: rx_state_nx = RX_COLLECT;
        endcase
    end

    assign o_rd_uart    = rx_pop;
    assign o_word_valid = (rx_state == RX_HOLD);

    // RX datapath: byte placement, byte counter, inter-byte timeout counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_cnt   <= '0;
            rx_tcnt  <= '0;
            o_word   <= '0;
            o_rx_err <= 1'b0;
        end else begin
            o_rx_err <= rx_timeout;
            if (rx_pop) begin
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (rx_cnt == CW'(k)) o_word[8*k +: 8] <= i_rx_data;
                end
                rx_cnt  <= rx_cnt + CW'(1);
                rx_tcnt <= '0;
            end else if (rx_timeout) begin
                rx_cnt  <= '0;
                rx_tcnt <= '0;
            end else if (rx_state == RX_HOLD) begin
                rx_tcnt <= '0;
                if (i_word_ready) rx_cnt <= '0;
            end else if ((TIMEOUT != 0) && (rx_cnt != '0)) begin
                rx_tcnt <= rx_tcnt + TW'(1);
            end else begin
                rx_tcnt <= '0;
            end
        end
    end

    // TX next-state and push decode; a push only happens when the FIFO has room.
    always_comb begin
        tx_state_nx = tx_state;
        tx_load     = 1'b0;
        tx_push     = 1'b0;
        tx_last     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (i_word_valid) begin
                    tx_load     = 1'b1;
                    tx_state_nx = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_push = i_reset & ~i_tx_full;
                tx_last = tx_push && (tx_idx == LAST_BYTE);
                if (tx_last) tx_state_nx = TX_IDLE;
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    assign o_word_ready = (tx_state == TX_IDLE);
    assign o_wr_uart    = tx_push;
    assign o_w_data     = tx_sr[7:0];

    // TX datapath: load the word, then shift out one byte per push.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_sr  <= '0;
            tx_idx <= '0;
        end else if (tx_load) begin
            tx_sr  <= i_word;
            tx_idx <= '0;
        end else if (tx_push) begin
            tx_sr  <= tx_sr >> 8;
            tx_idx <= tx_idx + CW'(1);
        end
    end

endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
- Sits directly downstream of the UART top block, on its FIFO side.
- RX path: pops bytes from the UART receive FIFO and assembles them, LSB-first, into DATA_W-bit words. Words are presented on a valid/ready port for the pipeline debug/loader logic.
- TX path: accepts DATA_W-bit words on a valid/ready port and pushes them LSB-first into the UART transmit FIFO, respecting FIFO-full.
- An inter-byte timeout discards stale partial words on the RX path.

Parameters:
- DATA_W, 32: word width; must be a multiple of 8. NBYTES = DATA_W/8 (≥1).
- TIMEOUT, 65535: idle clocks allowed between bytes of one RX word before the partial word is discarded; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_empty  in  1  UART RX FIFO empty.
- i_rx_data  in  8  UART RX FIFO head byte; valid while i_rx_empty=0.
- o_rd_uart  out  1  RX FIFO pop strobe.
- i_tx_full  in  1  UART TX FIFO full.
- o_wr_uart  out  1  TX FIFO push strobe.
- o_w_data  out  8  byte to push into the TX FIFO.
- o_word_valid  out  1  assembled RX word available.
- o_word  out  DATA_W  assembled RX word.
- i_word_ready  in  1  consumer accepts o_word.
- i_word_valid  in  1  TX word offered.
- i_word  in  DATA_W  TX word.
- o_word_ready  out  1  bridge can accept a TX word.
- o_rx_err  out  1  one-cycle pulse when a partial RX word is dropped by timeout.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - RX FSM goes to RX_COLLECT; TX FSM goes to TX_IDLE.
  - Byte counters, timeout counter, o_word and the TX shift register clear to 0.
  - o_word_valid=0, o_rx_err=0.
  - o_rd_uart and o_wr_uart are forced to 0 while reset is asserted.
  - After release: o_word_ready=1.
  - Reset mid-word discards all partial RX/TX data; nothing is resumed.
- RX FSM, state RX_COLLECT:
  - o_rd_uart = !i_rx_empty (combinational). FIFO is show-ahead: the head byte is captured in the same cycle as the pop.
  - Byte k (k=0..NBYTES-1) is written to o_word[8k+7:8k]; the byte counter increments.
  - When byte NBYTES-1 is popped: go to RX_HOLD. o_word_valid=1 from the next clock edge, so latency is 1 clock after the last pop.
- RX FSM, state RX_HOLD:
  - o_rd_uart=0; further bytes stay in the FIFO (backpressure).
  - o_word is stable while o_word_valid=1.
  - On a clock with i_word_ready=1: o_word_valid goes to 0 on the next edge, byte counter clears, return to RX_COLLECT.
  - Earliest next pop is the cycle after the handshake (at most one word per NBYTES+1 clocks).
- RX timeout (TIMEOUT>0):
  - Counter runs only in RX_COLLECT with byte count >0 and no pop that cycle. Any pop clears it.
  - When the counter reaches TIMEOUT-1 with no pop: byte counter and counter clear, o_rx_err=1 for exactly the next cycle. o_word contents are don't-care.
  - A pop in the threshold cycle wins: byte accepted, no error.
  - The counter is idle at byte count 0 and in RX_HOLD.
- TX FSM, state TX_IDLE:
  - o_word_ready=1 (registered; derived from state).
  - On i_word_valid & o_word_ready: latch i_word into the shift register, byte index=0, go to TX_SEND.
- TX FSM, state TX_SEND:
  - o_word_ready=0.
  - o_wr_uart = !i_tx_full (combinational); o_w_data = shift register [7:0].
  - On each push: shift right by 8 and increment the index.
  - After pushing byte NBYTES-1, return to TX_IDLE; o_word_ready=1 the next cycle.
  - While i_tx_full=1: no push; data and index hold.
  - Minimum NBYTES+1 clocks per word.
- RX and TX paths are fully independent and may be active in the same cycle.
- Counter widths are clog2 of NBYTES and TIMEOUT, minimum 1 bit.

Test Plan:
- Push 0x78,0x56,0x34,0x12 into the RX FIFO, i_word_ready=1 -> four single-cycle o_rd_uart pulses; o_word=0x12345678 with o_word_valid high for one cycle, 1 clock after the 4th pop.
- Eight bytes queued, i_word_ready=0 for 20 cycles after the first word -> o_rd_uart stays 0 during RX_HOLD and o_word stays constant; raising ready delivers the second word correctly.
- TIMEOUT=8: feed 0xAA,0xBB then stop -> o_rx_err pulses once, 8 clocks after the 2nd pop. Then feed 0x01,0x02,0x03,0x04 -> o_word=0x04030201, no extra error.
- TX word 0xDEADBEEF, with i_tx_full held high for 3 cycles after the 2nd byte -> pushes 0xEF,0xBE,0xAD,0xDE in order, no pushes while full, o_word_ready returns to 1 after the last push.
- Assert i_reset=0 after 2 RX bytes and mid-TX word -> all strobes drop immediately, o_word_valid=0. After release, a fresh 4-byte RX sequence yields the exact word with no stale bytes.
- Concurrent RX word and TX word -> both complete correctly with independent timing.
